// File: rtl/pll_mon_pkg.sv
// Shared types and defaults for the PLL clock monitor.
// Defaults assume a 16 MHz reference oscillator watching a 1 MHz PLL output.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } pll_mon_state_t;

  localparam int unsigned REF_HZ = 16_000_000;
  localparam int unsigned MON_HZ = 1_000_000;

  localparam int DEF_PERIOD_W   = 8;
  localparam int DEF_EXPECTED   = int'(REF_HZ / MON_HZ);
  localparam int DEF_TOL        = 1;
  localparam int DEF_LOCK_COUNT = 8;
  localparam int DEF_TIMEOUT    = 64;

  // True when meas lies within expected +/- tol (inclusive). The lower bound
  // is tested as meas + tol >= expected so a tolerance larger than the
  // nominal period never wraps below zero.
  function automatic logic in_tol(input logic [31:0] meas,
                                  input logic [31:0] expected,
                                  input logic [31:0] tol);
    return ((meas + tol) >= expected) && (meas <= (expected + tol));
  endfunction

endpackage

// File: rtl/pll_mon_edge_sync.sv
// Brings an asynchronous clock-like signal into the local clock domain and
// produces a one-cycle pulse for each rising transition.
module pll_mon_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  // Two metastability flops, then one history flop for the edge compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      hist_p2 <= 1'b0;
    end else begin
      sync_p0 <= sig;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign rise = sync_p1 & ~hist_p2;

endmodule

// File: rtl/pll_clock_monitor.sv
// PLL lock monitor: measures the PLL output period in reference cycles,
// declares lock after LOCK_COUNT consecutive in-tolerance periods, and
// reports faults and stalls. Define PLL_MON_HIST_EN to add running
// period_min / period_max outputs.
module pll_clock_monitor
  import pll_mon_pkg::*;
#(
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int EXPECTED   = DEF_EXPECTED,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                REFERENCECLK,
  input  logic                RESET,
  input  logic                enable,
  input  logic                mon_clk,
  input  logic                clear,
  output logic                locked,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                fault,
  output logic                fault_sticky,
  output logic                stall
`ifdef PLL_MON_HIST_EN
  ,
  output logic [PERIOD_W-1:0] period_min,
  output logic [PERIOD_W-1:0] period_max
`endif
);

  localparam int GCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [PERIOD_W-1:0] CNT_MAX   = '1;
  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT);
  localparam logic [GCW-1:0]      LOCK_LAST = GCW'(LOCK_COUNT - 1);

  pll_mon_state_t      state;
  logic [PERIOD_W-1:0] cnt;
  logic [GCW-1:0]      good_cnt;
  logic                mon_edge;
  logic [PERIOD_W:0]   meas_ext;
  logic                good;
  logic                timeout;

  pll_mon_edge_sync u_edge_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .sig   (mon_clk),
    .rise  (mon_edge)
  );

  // One spare bit keeps the tolerance compare free of wrap-around
  assign meas_ext = {1'b0, cnt};
  assign good     = in_tol(32'(meas_ext), 32'(EXPECTED), 32'(TOL));
  // An edge landing on the timeout cycle is a measurement, not a stall
  assign timeout  = (cnt == TIMEOUT_V) && !mon_edge;

  // Period counter: held at zero while idle, restarts at 1 on each edge
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (mon_edge) begin
      cnt <= PERIOD_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

  // Lock state machine with registered status, measurement and pulse outputs
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state        <= IDLE;
      good_cnt     <= '0;
      locked       <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
      stall        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      fault        <= 1'b0;
      stall        <= 1'b0;
      // A fault raised below in the same cycle overrides this clear
      fault_sticky <= fault_sticky & ~clear;

      if (!enable) begin
        state    <= IDLE;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ARM;
            good_cnt <= '0;
          end

          ARM: begin
            // First edge only establishes a reference point
            if (mon_edge) begin
              state    <= ACQUIRE;
              good_cnt <= '0;
            end
          end

          ACQUIRE: begin
            if (mon_edge) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (good) begin
                good_cnt <= good_cnt + GCW'(1);
                if (good_cnt == LOCK_LAST) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end else if (timeout) begin
              state    <= ARM;
              good_cnt <= '0;
              stall    <= 1'b1;
            end
          end

          LOCKED: begin
            if (mon_edge) begin
              period       <= cnt;
              period_valid <= 1'b1;
              if (!good) begin
                state        <= ACQUIRE;
                good_cnt     <= '0;
                locked       <= 1'b0;
                fault        <= 1'b1;
                fault_sticky <= 1'b1;
              end
            end else if (timeout) begin
              state        <= ARM;
              good_cnt     <= '0;
              locked       <= 1'b0;
              stall        <= 1'b1;
              fault        <= 1'b1;
              fault_sticky <= 1'b1;
            end
          end

          default: begin
            state    <= IDLE;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PLL_MON_HIST_EN
  // Running extremes of reported periods; clear restarts the window and a
  // sample arriving with clear becomes the first sample of the new window
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      period_min <= '1;
      period_max <= '0;
    end else if (clear) begin
      if (period_valid) begin
        period_min <= period;
        period_max <= period;
      end else begin
        period_min <= '1;
        period_max <= '0;
      end
    end else if (period_valid) begin
      if (period < period_min) period_min <= period;
      if (period > period_max) period_max <= period;
    end
  end
`endif

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Randomized bench for pll_clock_monitor. mon_clk is described as a list of
// rise-to-rise gaps; an event-level model predicts every measurement and
// stall the monitor must report, and a monitor process matches them.
module tb_pll_clock_monitor;

  localparam int PW    = 8;
  localparam int EXP   = 16;
  localparam int TOL   = 1;
  localparam int LOCKN = 8;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          mon_clk;
  logic          clear;
  logic          locked;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          fault;
  logic          fault_sticky;
  logic          stall;
`ifdef PLL_MON_HIST_EN
  logic [PW-1:0] period_min;
  logic [PW-1:0] period_max;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int spurious = 0;

  typedef struct {
    bit is_stall;
    int per;
    bit flt;
    bit lck;
    bit stk;
    int mn;
    int mx;
  } ev_t;

  ev_t expq[$];
  ev_t ev;

  // Abstract model state: 0 = waiting for a reference edge, 1 = acquiring, 2 = locked
  int m_state;
  int m_run;
  int last_gap;
  int m_min;
  int m_max;
  bit m_sticky;
  bit hist_chk;
  int hist_mn;
  int hist_mx;

  pll_clock_monitor #(
    .PERIOD_W   (PW),
    .EXPECTED   (EXP),
    .TOL        (TOL),
    .LOCK_COUNT (LOCKN),
    .TIMEOUT    (TMO)
  ) dut (
    .REFERENCECLK (clk),
    .RESET        (rst_n),
    .enable       (enable),
    .mon_clk      (mon_clk),
    .clear        (clear),
    .locked       (locked),
    .period       (period),
    .period_valid (period_valid),
    .fault        (fault),
    .fault_sticky (fault_sticky),
    .stall        (stall)
`ifdef PLL_MON_HIST_EN
    ,
    .period_min   (period_min),
    .period_max   (period_max)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_run    = 0;
    m_sticky = 1'b0;
    m_min    = (1 << PW) - 1;
    m_max    = 0;
  endtask

  // Drive one mon_clk rise followed by a gap of g reference cycles. The rise
  // closes the previous gap, so the model first scores that gap, then
  // decides whether the coming gap is long enough to stall.
  task automatic send(input int g);
    int  p;
    bit  is_good;
    bit  flt;
    if (m_state == 0) begin
      m_state = 1;
      m_run   = 0;
    end else begin
      p       = last_gap;
      is_good = (p >= EXP - TOL) && (p <= EXP + TOL);
      flt     = 1'b0;
      if (m_state == 1) begin
        if (is_good) begin
          m_run++;
          if (m_run == LOCKN) m_state = 2;
        end else begin
          m_run = 0;
        end
      end else if (!is_good) begin
        flt      = 1'b1;
        m_sticky = 1'b1;
        m_state  = 1;
        m_run    = 0;
      end
      if (p < m_min) m_min = p;
      if (p > m_max) m_max = p;
      expq.push_back('{1'b0, p, flt, (m_state == 2), m_sticky, m_min, m_max});
    end
    if (g > TMO && m_state != 0) begin
      flt = (m_state == 2);
      if (flt) m_sticky = 1'b1;
      expq.push_back('{1'b1, 0, flt, 1'b0, m_sticky, m_min, m_max});
      m_state = 0;
    end
    last_gap = g;
    mon_clk = 1'b1;
    repeat (g / 2) @(negedge clk);
    mon_clk = 1'b0;
    repeat (g - g / 2) @(negedge clk);
  endtask

  // Match every reported measurement or stall against the model
  always @(negedge clk) begin
    if (rst_n) begin
`ifdef PLL_MON_HIST_EN
      if (hist_chk) begin
        chk("hist_min", 32'(period_min), 32'(hist_mn));
        chk("hist_max", 32'(period_max), 32'(hist_mx));
      end
`endif
      hist_chk = 1'b0;
      if (period_valid || stall) begin
        chk("evt_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          ev = expq.pop_front();
          chk("stall_kind", 32'(stall), 32'(ev.is_stall));
          if (!ev.is_stall) begin
            chk("period", 32'(period), 32'(ev.per));
            hist_chk = 1'b1;
            hist_mn  = ev.mn;
            hist_mx  = ev.mx;
          end
          chk("fault", 32'(fault), 32'(ev.flt));
          chk("locked", 32'(locked), 32'(ev.lck));
          chk("sticky", 32'(fault_sticky), 32'(ev.stk));
        end
      end else if (fault) begin
        spurious++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not complete, %0d events pending", expq.size());
    $fatal(1);
  end

  int dir_gaps[] = '{16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 19,
                     16, 16, 16, 16, 16, 16, 16, 16, 16, 100,
                     16, 16, 16, 16, 16, 16, 16, 16, 16, 16, 100,
                     15, 17, 15, 17, 14, 15, 17, 15, 17, 15, 17, 15, 17, 16,
                     64, 16, 16, 65, 16, 16, 100};

  initial begin
    int r;
    int g;
    rst_n    = 1'b0;
    enable   = 1'b0;
    mon_clk  = 1'b0;
    clear    = 1'b0;
    last_gap = 0;
    hist_chk = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_pvalid", 32'(period_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_sticky", 32'(fault_sticky), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
`ifdef PLL_MON_HIST_EN
    chk("rst_min", 32'(period_min), 32'((1 << PW) - 1));
    chk("rst_max", 32'(period_max), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    repeat (2) @(negedge clk);

    foreach (dir_gaps[i]) send(dir_gaps[i]);

    // Lock, then drop enable mid-gap: lock falls, sticky is retained
    for (int i = 0; i < 10; i++) send(16);
    send(30);
    chk("locked_before_disable", 32'(locked), 32'(m_state == 2));
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("locked_disabled", 32'(locked), 32'd0);
    chk("sticky_disabled", 32'(fault_sticky), 32'(m_sticky));
    chk("stall_disabled", 32'(stall), 32'd0);
    m_state = 0;

    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 32'(fault_sticky), 32'd0);
`ifdef PLL_MON_HIST_EN
    chk("clr_min", 32'(period_min), 32'((1 << PW) - 1));
    chk("clr_max", 32'(period_max), 32'd0);
`endif
    m_sticky = 1'b0;
    m_min    = (1 << PW) - 1;
    m_max    = 0;
    enable   = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      g = 15 + int'($urandom_range(0, 2));
      else if (r < 85) g = int'($urandom_range(10, 30));
      else if (r < 95) g = 63 + int'($urandom_range(0, 2));
      else             g = int'($urandom_range(66, 120));
      send(g);
    end

    // Reset in the middle of acquisition wipes everything at once
    send(100);
    for (int i = 0; i < 4; i++) send(16);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_period", 32'(period), 32'd0);
    chk("mid_rst_pvalid", 32'(period_valid), 32'd0);
    chk("mid_rst_fault", 32'(fault), 32'd0);
    chk("mid_rst_sticky", 32'(fault_sticky), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("pending_at_reset", 32'(expq.size()), 32'd0);
    expq.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) send(16);
    send(100);

    chk("pending_at_end", 32'(expq.size()), 32'd0);
    chk("spurious_fault", 32'(spurious), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
